// File: rtl/sort_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_pkg : shared types and constants for the sort host bridge family
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package sort_pkg;

  localparam int ELEM_W_DEF   = 32;
  localparam int NUM_ELEM_DEF = 32;
  localparam int TIMEOUT_DEF  = 65535;

  // Unused slots carry all-ones so padding collects at the tail of an ascending sort
  localparam logic [ELEM_W_DEF-1:0] PAD_VALUE_DEF = '1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } sort_state_e;

  // Width of the packed key bus
  function automatic int bus_w(input int elem_w, input int num_elem);
    return elem_w * num_elem;
  endfunction

  // LSB of key slot idx inside the packed bus
  function automatic int slot_lsb(input int idx, input int elem_w);
    return idx * elem_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_unpack_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_unpack_stream : turns a captured packed word plus key count into a
//                      valid/ready key stream with a last marker
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sort_unpack_stream
  import sort_pkg::*;
#(
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int NUM_ELEM = NUM_ELEM_DEF,
  parameter int BUS_W    = ELEM_W * NUM_ELEM,
  parameter int CNT_W    = $clog2(NUM_ELEM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BUS_W-1:0]  word_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ELEM_W-1:0] data_o,
  output logic              last_o,
  output logic              done_o
);

  logic [BUS_W-1:0] buf_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] ocnt_q;
  logic             active_q;
  logic             is_last;

  assign is_last = (ocnt_q == count_q - 1'b1);

  // Capture the word on load, then step one slot per accepted key until the count is exhausted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      count_q  <= '0;
      ocnt_q   <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      buf_q    <= word_i;
      count_q  <= count_i;
      ocnt_q   <= '0;
      active_q <= (count_i != '0);
    end else if (active_q && ready_i) begin
      if (is_last) begin
        active_q <= 1'b0;
      end else begin
        ocnt_q <= ocnt_q + 1'b1;
      end
    end
  end

  assign valid_o = active_q;
  assign data_o  = buf_q[slot_lsb(int'(ocnt_q), ELEM_W) +: ELEM_W];
  assign last_o  = active_q & is_last;
  assign done_o  = active_q & ready_i & is_last;

endmodule
`default_nettype wire

// File: rtl/sort_host_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_host_bridge : gathers a key stream into one packed sorter word,
//                    launches the sorter, and streams the sorted keys back
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sort_host_bridge
  import sort_pkg::*;
#(
  parameter int                ELEM_W    = ELEM_W_DEF,
  parameter int                NUM_ELEM  = NUM_ELEM_DEF,
  parameter logic [ELEM_W-1:0] PAD_VALUE = '1,
  parameter int                TIMEOUT   = TIMEOUT_DEF,
  localparam int               BUS_W     = bus_w(ELEM_W, NUM_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic              start_sort,
  output logic [BUS_W-1:0]  sort_data_in,
  input  logic              done_sort,
  input  logic [BUS_W-1:0]  sort_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              sort_error,
  output logic [15:0]       sort_cycles
);

  localparam int               CNT_W     = $clog2(NUM_ELEM + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_ELEM - 1);
  localparam logic [BUS_W-1:0] PAD_BUS   = {NUM_ELEM{PAD_VALUE}};
  localparam logic [15:0]      TMR_LIMIT = 16'(TIMEOUT - 1);

  sort_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] valid_cnt_q;
  logic [15:0]      timer_q;
  logic [15:0]      sort_cycles_q;
  logic             done_q;
  logic [BUS_W-1:0] data_in_q;

  logic             in_fire;
  logic             fill_end;
  logic             done_rise;
  logic             timed_out;
  logic             load_buf;
  logic             drain_end;
  logic [16:0]      elapsed;
  logic [15:0]      cycles_sat;

  assign in_fire   = in_valid & in_ready;
  assign fill_end  = in_fire & (in_last | (cnt_q == LAST_IDX));
  // Only an edge counts, so a level left high by an earlier run never completes a batch
  assign done_rise = done_sort & ~done_q;
  // timer_q is cleared in LAUNCH, so timer_q+1 is the number of cycles since start_sort
  assign timed_out = (timer_q == TMR_LIMIT);
  assign elapsed    = {1'b0, timer_q} + 17'd1;
  assign cycles_sat = elapsed[16] ? 16'hFFFF : elapsed[15:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completion edge beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_end) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (done_rise)      state_d = DRAIN;
        else if (timed_out) state_d = FILL;
      end
      DRAIN:   if (drain_end) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State-decoded outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready   = 1'b0;
    start_sort = 1'b0;
    sort_error = 1'b0;
    load_buf   = 1'b0;
    case (state_q)
      FILL:    in_ready = ~rst;
      LAUNCH:  start_sort = 1'b1;
      WAIT: begin
        load_buf   = done_rise;
        sort_error = timed_out & ~done_rise;
      end
      default: ;
    endcase
  end

  // Key packing, launch timer and cycle statistics; the packed word is refilled
  // with padding whenever a batch finishes or is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      valid_cnt_q   <= '0;
      timer_q       <= '0;
      sort_cycles_q <= '0;
      done_q        <= 1'b0;
      data_in_q     <= PAD_BUS;
    end else begin
      done_q <= done_sort;
      case (state_q)
        FILL: begin
          if (in_fire) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
              if (i == int'(cnt_q)) begin
                data_in_q[slot_lsb(i, ELEM_W) +: ELEM_W] <= in_data;
              end else if (fill_end && (i > int'(cnt_q))) begin
                data_in_q[slot_lsb(i, ELEM_W) +: ELEM_W] <= PAD_VALUE;
              end
            end
            if (fill_end) begin
              cnt_q       <= '0;
              valid_cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LAUNCH: timer_q <= '0;
        WAIT: begin
          if (!timed_out) timer_q <= timer_q + 1'b1;
          if (done_rise) begin
            sort_cycles_q <= cycles_sat;
          end else if (timed_out) begin
            data_in_q <= PAD_BUS;
          end
        end
        DRAIN: if (drain_end) data_in_q <= PAD_BUS;
        default: ;
      endcase
    end
  end

  sort_unpack_stream #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEM (NUM_ELEM),
    .BUS_W    (BUS_W),
    .CNT_W    (CNT_W)
  ) u_unpack (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_buf),
    .word_i  (sort_data_out),
    .count_i (valid_cnt_q),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (out_data),
    .last_o  (out_last),
    .done_o  (drain_end)
  );

  assign sort_data_in = data_in_q;
  assign sort_cycles  = sort_cycles_q;

endmodule
`default_nettype wire

// File: doc/sort_host_bridge.md
Name: sort_host_bridge

Overview:
- Initiator-side companion to the team's merge sorter. It collects a stream of 32-bit keys into one packed data_in word and pulses start_sort.
- It then waits for done_sort, captures data_out, and streams the sorted keys back out over a valid/ready interface.
- It sits between a DMA/stream source and the sorter macro, so the sorter never sees a partially loaded word.

Parameters:
ELEM_W, 32, width of one key
NUM_ELEM, 32, keys per sort batch; BUS_W = ELEM_W*NUM_ELEM (1024 at defaults)
PAD_VALUE, all-ones, fill value for unused slots, so padding sorts to the tail in ascending order
TIMEOUT, 65535, maximum cycles to wait for done_sort after start_sort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input key valid
in_ready  out  1  bridge accepts a key
in_data  in  ELEM_W  input key
in_last  in  1  marks the final key of a batch (may come early)
start_sort  out  1  one-cycle launch pulse to the sorter
sort_data_in  out  BUS_W  packed keys; key i at bits [i*ELEM_W +: ELEM_W]
done_sort  in  1  sorter completion level
sort_data_out  in  BUS_W  sorted packed keys, same packing
out_valid  out  1  sorted key valid
out_ready  in  1  downstream accepts
out_data  out  ELEM_W  sorted key
out_last  out  1  final valid key of the batch
sort_error  out  1  one-cycle pulse on timeout
sort_cycles  out  16  cycles from start_sort to done edge, last good batch

Behaviour:
- Reset is async active-high; clock is clk. Every output and state register reset applies immediately:
  - state FILL, counters 0, sort_data_in all PAD_VALUE;
  - start_sort/out_valid/out_last/sort_error 0, in_ready 0 during reset, sort_cycles 0.
- Reset mid-operation abandons the batch; no partial output is emitted after release.
- done_rise = done_sort & ~done_q. done_q is registered every cycle in all states. A level that stays high from a prior run never counts as completion.
- FILL:
  - in_ready=1. A handshake writes in_data to slot cnt and increments cnt.
  - If the handshake has in_last=1 or cnt==NUM_ELEM-1:
    - slots above cnt are loaded with PAD_VALUE in the same cycle;
    - valid_cnt = cnt+1 is latched; go to LAUNCH.
  - in_valid with in_last on the very first key gives a one-key batch.
- LAUNCH: in_ready=0, start_sort=1 for exactly one cycle, timer cleared; go to WAIT. sort_data_in is held stable from LAUNCH until DRAIN completes.
- WAIT:
  - Timer increments each cycle.
  - On done_rise: capture sort_data_out into the output buffer, sort_cycles <= timer (saturating at 16'hFFFF), ocnt=0; go to DRAIN.
  - If the timer reaches TIMEOUT without done_rise: sort_error pulses 1 cycle, the batch is discarded, sort_data_in refilled with PAD_VALUE; go to FILL.
  - done_rise on the same cycle as timeout wins, with no error.
- DRAIN:
  - out_valid=1, out_data = buffer slot ocnt, out_last = (ocnt==valid_cnt-1).
  - out_data/out_last hold while out_ready=0.
  - On handshake ocnt increments. After the handshake on the last key: out_valid=0, sort_data_in refilled with PAD_VALUE; go to FILL.
  - Only valid_cnt keys are emitted; tail padding is never output. Keys equal to PAD_VALUE still emit correctly, since only the count matters.
- Latency:
  - last input handshake -> start_sort: 1 cycle;
  - done_rise -> first out_valid: 1 cycle;
  - one key per cycle under continuous out_ready.
- No input is accepted outside FILL, so back-to-back batches serialise.

Decomposition:
- Shared package sort_pkg holds:
  - ELEM_W/NUM_ELEM defaults and the BUS_W derivation;
  - the state enum (FILL, LAUNCH, WAIT, DRAIN);
  - the PAD_VALUE constant;
  - the slot-index function i*ELEM_W.
- One natural sub-module: sort_unpack_stream, a captured wide word plus count producing a valid/ready key stream with last. It is reusable by other algorithm blocks.

Test Plan:
- Full batch: keys 31..0, sorter model returns 0..31, done rises 40 cycles after start -> start_sort single pulse 1 cycle after 32nd key; out_data 0..31, out_last on key 31; sort_cycles=40.
- Short batch: keys 7,3,5 with in_last on 5 -> sort_data_in slots 3..31 = 0xFFFFFFFF; output 3,5,7, out_last on 7, no pad emitted.
- Backpressure: out_ready toggles 1,0,0,1 during DRAIN -> out_data/out_last stable while stalled; no key dropped or duplicated; in_ready stays 0 until last key drains.
- Stale done: done_sort held high before launch and never toggled -> no DRAIN; sort_error pulses after TIMEOUT cycles (use TIMEOUT=100); in_ready returns 1 next cycle.
- Async reset asserted in WAIT and mid-DRAIN (between edges) -> outputs clear immediately; after release in_ready=1 and the next batch sorts correctly.
- Single key with in_last -> launch; output exactly one key with out_last=1.
